stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (1..64).
REQ-002 Parameter N_OUT, default 8, number of output channels (2..16; need not be a power of two).
REQ-003 Parameter SEL_W, default 3, select width; SHALL be at least ceil(log2(N_OUT)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block can accept the input beat this cycle.
REQ-008 in_data  input  DATA_W  input payload.
REQ-009 in_sel  input  SEL_W  destination channel index.
REQ-010 out_valid  output  N_OUT  per-channel output beat present; bit i is channel i.
REQ-011 out_ready  input  N_OUT  per-channel sink ready.
REQ-012 out_data  output  N_OUT*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-013 sel_err  output  1  sticky flag: an out-of-range select was received.

Function
REQ-014 Transfer: an input handshake occurs when in_valid and in_ready are both 1. An output handshake on channel i occurs when out_valid[i] and out_ready[i] are both 1.
REQ-015 Each channel SHALL hold one output slot: a valid bit plus a DATA_W data register.
REQ-016 Latency: an accepted beat SHALL appear on out_valid/out_data of channel in_sel in the next cycle.
REQ-017 in_ready SHALL be 1 when in_sel >= N_OUT, or when slot in_sel is empty, or when slot in_sel is being drained in the same cycle. in_ready is combinational from in_sel, out_valid and out_ready.
REQ-018 Simultaneous drain and fill of the same slot SHALL reload it with the new beat with no bubble. out_valid stays 1.
REQ-019 A slot not addressed by an accepted beat SHALL clear its valid bit on its own output handshake and otherwise hold.
REQ-020 out_data[i] SHALL stay stable while out_valid[i]=1 and out_ready[i]=0.
REQ-021 An accepted beat with in_sel >= N_OUT SHALL be dropped, SHALL change no slot, and SHALL set sel_err to 1. sel_err is cleared only by rst.
REQ-022 The block SHALL never reorder beats within a channel and SHALL never duplicate a beat.

Reset
REQ-023 While rst=1 at a clock edge: all out_valid bits SHALL go to 0, out_data SHALL go to 0, sel_err SHALL go to 0, and any in-flight beat SHALL be discarded.
REQ-024 in_ready SHALL be forced to 0 while rst=1.
REQ-025 Reset asserted mid-stream SHALL leave no residual valid beat after the clock edge.

Configuration
REQ-026 Macro STREAM_DEMUX_BCAST_EN, when defined, SHALL add port in_bcast (input, 1 bit).
REQ-027 With the macro defined and in_bcast=1, the beat SHALL be accepted only when every slot is empty or draining that cycle. The beat SHALL then load into all N_OUT slots, and in_sel SHALL be ignored, so sel_err is not affected.
REQ-028 Without the macro, the in_bcast port SHALL not exist and the broadcast logic SHALL not be present.

Structure
REQ-029 The shared package stream_demux_pkg SHALL hold the default constants (DATA_W=8, N_OUT=8, SEL_W=3) and a clog2 function used to check SEL_W at elaboration.
REQ-030 Sub-module demux_out_slot (one-entry valid/data register with load, drain and hold) SHALL be instantiated N_OUT times through a generate loop.

Verification
REQ-031 Sweep: with all out_ready=1, send data 0xA0+k with sel=k for k=0..7. Each channel k SHALL present 0xA0+k exactly one cycle after acceptance, and in_ready SHALL stay 1 throughout.
REQ-032 Back-pressure: hold out_ready[3]=0 and send two beats to sel=3. The first SHALL be held stable, and in_ready SHALL be 0 for the second. Raising out_ready[3] SHALL deliver both in order, with the second appearing the cycle after the first drains.
REQ-033 Same-cycle drain and fill: hold out_ready[5]=1 and stream 0x11, 0x22, 0x33 back-to-back to sel=5. out_valid[5] SHALL stay 1 for three consecutive cycles with no bubble.
REQ-034 Illegal select: with N_OUT=6, send sel=7 and data 0xFF. The beat SHALL be accepted, no out_valid bit SHALL rise, and sel_err SHALL be 1 from the next cycle until rst.
REQ-035 Mid-stream reset: fill slots 0..2 with out_ready=0, then pulse rst for one cycle. All out_valid bits, out_data and sel_err SHALL be 0 after the edge, and in_ready SHALL be 0 during rst.
REQ-036 Broadcast (macro defined): hold out_ready[2]=0 with slot 2 full, then drive in_bcast=1 with data 0x5A. in_ready SHALL be 0. After slot 2 drains, the beat SHALL appear on all channels with data 0x5A.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared defaults and elaboration helpers for the stream demultiplexer.
package stream_demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_OUT  = 8;
  localparam int DEF_SEL_W  = 3;

  // Smallest r with 2**r >= v; used to validate the select width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output slot: a valid bit plus a data register with load, drain and hold.
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // A load wins over a drain, so a same-cycle drain and fill keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Valid/ready stream demultiplexer: routes each beat to the slot chosen by in_sel.
// Optional broadcast input in_bcast is enabled by defining STREAM_DEMUX_BCAST_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                    in_bcast,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    sel_err
);

  localparam int SEL_SPAN = 1 << SEL_W;

  if (SEL_W < clog2(N_OUT)) begin : g_bad_sel_w
    $error("stream_demux: SEL_W too narrow for N_OUT");
  end

  logic [N_OUT-1:0]    free;
  logic [SEL_SPAN-1:0] free_pad;
  logic [N_OUT-1:0]    load;
  logic                sel_ok;
  logic                accept;
  logic                err_set;

  assign free   = ~out_valid | out_ready;
  assign sel_ok = {1'b0, in_sel} < (SEL_W+1)'(N_OUT);

  // Selects past the last channel read as free so illegal beats are always taken.
  always_comb begin
    free_pad            = '1;
    free_pad[N_OUT-1:0] = free;
  end

`ifdef STREAM_DEMUX_BCAST_EN
  assign in_ready = !rst && (in_bcast ? (&free) : free_pad[in_sel]);
  assign accept   = in_valid && in_ready;
  assign err_set  = accept && !in_bcast && !sel_ok;

  always_comb begin
    load = '0;
    for (int i = 0; i < N_OUT; i++)
      load[i] = accept && (in_bcast || ({1'b0, in_sel} == (SEL_W+1)'(i)));
  end
`else
  assign in_ready = !rst && free_pad[in_sel];
  assign accept   = in_valid && in_ready;
  assign err_set  = accept && !sel_ok;

  always_comb begin
    load = '0;
    for (int i = 0; i < N_OUT; i++)
      load[i] = accept && ({1'b0, in_sel} == (SEL_W+1)'(i));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)          sel_err <= 1'b0;
    else if (err_set) sel_err <= 1'b1;
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_out_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[g]),
      .load_data(in_data),
      .ready    (out_ready[g]),
      .valid    (out_valid[g]),
      .data     (out_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios on an 8-channel instance and a
// randomized run against a reference model on a 6-channel instance.
module tb_stream_demux;

  logic        clk;
  logic        rst;

  logic        v8, rdy8, err8;
  logic [2:0]  s8;
  logic [7:0]  d8, ov8, r8;
  logic [63:0] od8;

  logic        v6, rdy6, err6;
  logic [2:0]  s6;
  logic [7:0]  d6;
  logic [5:0]  ov6, r6;
  logic [47:0] od6;
`ifdef STREAM_DEMUX_BCAST_EN
  logic        b8, b6;
`endif

  int n_chk;
  int n_err;

  stream_demux #(.DATA_W(8), .N_OUT(8), .SEL_W(3)) u8 (
    .clk(clk), .rst(rst),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(b8),
`endif
    .in_valid(v8), .in_ready(rdy8), .in_data(d8), .in_sel(s8),
    .out_valid(ov8), .out_ready(r8), .out_data(od8), .sel_err(err8)
  );

  stream_demux #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) u6 (
    .clk(clk), .rst(rst),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(b6),
`endif
    .in_valid(v6), .in_ready(rdy6), .in_data(d6), .in_sel(s6),
    .out_valid(ov6), .out_ready(r6), .out_data(od6), .sel_err(err6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the 6-channel instance: one slot per channel.
  logic       mv [6];
  logic [7:0] md [6];
  logic       merr;

  initial begin
    logic        exp_rdy;
    logic [5:0]  eov;
    logic [47:0] eod;
    int          sel;

    clk = 1'b0; rst = 1'b1;
    v8 = 0; s8 = 0; d8 = 0; r8 = 0;
    v6 = 0; s6 = 0; d6 = 0; r6 = 0;
`ifdef STREAM_DEMUX_BCAST_EN
    b8 = 0; b6 = 0;
`endif
    n_chk = 0; n_err = 0;

    // Reset state and in_ready forced low during reset
    v8 = 1'b1; v6 = 1'b1;
    step();
    step();
    check("rst_in_ready8", 64'(rdy8), 64'd0);
    check("rst_in_ready6", 64'(rdy6), 64'd0);
    rst = 1'b0; v8 = 1'b0; v6 = 1'b0;
    #1;
    check("rst_out_valid8", 64'(ov8), 64'd0);
    check("rst_out_data8", od8, 64'd0);
    check("rst_sel_err8", 64'(err8), 64'd0);
    check("rst_out_valid6", 64'(ov6), 64'd0);

    // Sweep: each channel gets 0xA0+k one cycle after acceptance
    r8 = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      v8 = 1'b1; s8 = 3'(k); d8 = 8'(8'hA0 + k);
      #1;
      check("sweep_in_ready", 64'(rdy8), 64'd1);
      step();
      check("sweep_valid", 64'(ov8), 64'(8'd1 << k));
      check("sweep_data", 64'(od8[k*8 +: 8]), 64'(8'hA0 + k));
    end
    v8 = 1'b0;
    step();
    check("sweep_idle", 64'(ov8), 64'd0);

    // Back-pressure on channel 3
    r8 = 8'hF7;
    v8 = 1'b1; s8 = 3'd3; d8 = 8'h31;
    step();
    d8 = 8'h32;
    #1;
    check("bp_in_ready_blocked", 64'(rdy8), 64'd0);
    step();
    step();
    check("bp_hold_valid", 64'(ov8[3]), 64'd1);
    check("bp_hold_data", 64'(od8[24 +: 8]), 64'h31);
    r8 = 8'hFF;
    #1;
    check("bp_in_ready_drain", 64'(rdy8), 64'd1);
    step();
    v8 = 1'b0;
    check("bp_second_valid", 64'(ov8[3]), 64'd1);
    check("bp_second_data", 64'(od8[24 +: 8]), 64'h32);
    step();
    check("bp_empty", 64'(ov8), 64'd0);

    // Same-cycle drain and fill on channel 5
    v8 = 1'b1; s8 = 3'd5;
    for (int k = 1; k <= 3; k++) begin
      d8 = 8'(k * 8'h11);
      #1;
      check("df_in_ready", 64'(rdy8), 64'd1);
      step();
      check("df_valid", 64'(ov8[5]), 64'd1);
      check("df_data", 64'(od8[40 +: 8]), 64'(k * 8'h11));
    end
    v8 = 1'b0;
    step();
    check("df_done", 64'(ov8), 64'd0);

    // Illegal select on the 6-channel instance
    r6 = 6'h3F;
    v6 = 1'b1; s6 = 3'd7; d6 = 8'hFF;
    #1;
    check("ill_in_ready", 64'(rdy6), 64'd1);
    step();
    v6 = 1'b0;
    check("ill_no_valid", 64'(ov6), 64'd0);
    check("ill_sel_err", 64'(err6), 64'd1);
    step();
    step();
    check("ill_sel_err_sticky", 64'(err6), 64'd1);

    // Mid-stream reset with slots 0..2 full
    r8 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      v8 = 1'b1; s8 = 3'(k); d8 = 8'(8'hC0 + k);
      step();
    end
    check("mr_filled", 64'(ov8), 64'h07);
    s8 = 3'd4; d8 = 8'hEE;
    rst = 1'b1;
    #1;
    check("mr_in_ready_rst", 64'(rdy8), 64'd0);
    step();
    rst = 1'b0; v8 = 1'b0;
    #1;
    check("mr_valid", 64'(ov8), 64'd0);
    check("mr_data", od8, 64'd0);
    check("mr_sel_err6", 64'(err6), 64'd0);
    check("mr_valid6", 64'(ov6), 64'd0);

    // Randomized run on the 6-channel instance against the model
    for (int i = 0; i < 6; i++) begin
      mv[i] = 1'b0;
      md[i] = 8'h00;
    end
    merr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      v6  = 1'($urandom);
      sel = int'($urandom_range(0, 7));
      s6  = 3'(sel);
      d6  = 8'($urandom);
      r6  = 6'($urandom);
      #1;
      if (rst)           exp_rdy = 1'b0;
      else if (sel >= 6) exp_rdy = 1'b1;
      else               exp_rdy = !mv[sel] || r6[sel];
      for (int i = 0; i < 6; i++) begin
        eov[i]        = mv[i];
        eod[i*8 +: 8] = md[i];
      end
      check("rnd_in_ready", 64'(rdy6), 64'(exp_rdy));
      check("rnd_out_valid", 64'(ov6), 64'(eov));
      check("rnd_out_data", 64'(od6), 64'(eod));
      check("rnd_sel_err", 64'(err6), 64'(merr));
      if (rst) begin
        for (int i = 0; i < 6; i++) begin
          mv[i] = 1'b0;
          md[i] = 8'h00;
        end
        merr = 1'b0;
      end else begin
        for (int i = 0; i < 6; i++)
          if (mv[i] && r6[i]) mv[i] = 1'b0;
        if (v6 && exp_rdy) begin
          if (sel < 6) begin
            mv[sel] = 1'b1;
            md[sel] = d6;
          end else begin
            merr = 1'b1;
          end
        end
      end
      step();
    end
    rst = 1'b0; v6 = 1'b0;

`ifdef STREAM_DEMUX_BCAST_EN
    // Broadcast waits for every slot to be free, then loads all of them
    rst = 1'b1;
    step();
    rst = 1'b0;
    r8 = 8'hFB;
    v8 = 1'b1; s8 = 3'd2; d8 = 8'h22;
    step();
    b8 = 1'b1; d8 = 8'h5A; s8 = 3'd7;
    #1;
    check("bc_in_ready_blocked", 64'(rdy8), 64'd0);
    step();
    check("bc_slot2_held", 64'(ov8), 64'h04);
    r8 = 8'hFF;
    #1;
    check("bc_in_ready", 64'(rdy8), 64'd1);
    step();
    v8 = 1'b0; b8 = 1'b0;
    check("bc_all_valid", 64'(ov8), 64'hFF);
    check("bc_all_data", od8, {8{8'h5A}});
    check("bc_no_sel_err", 64'(err8), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
